// File: rtl/dp_seq_arbiter_if.sv
// Requester/datapath-control bundle for the shared select/mux datapath.
//
// Handshake: a requester raises its req bit and holds it until it sees its
// done bit. The arbiter answers with gnt (one-hot, held from P1 through DONE)
// and a one-cycle done pulse. rep_cnt is sampled only on the grant edge, and
// abort is a single-cycle synchronous cancel. There is no other flow control.
interface dp_seq_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int REP_W = 4
);
    logic [NREQ-1:0]  req;
    logic [REP_W-1:0] rep_cnt;
    logic             abort;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic [NREQ-1:0]  done;
    logic             sel1, sel2, sel3, sel4;
    logic             mux1, mux2;
    logic             Aout, Dout;
    logic [2:0]       dbg_state;

    // Requesting side
    modport master (
        output req, rep_cnt, abort,
        input  gnt, busy, done, sel1, sel2, sel3, sel4, mux1, mux2, Aout, Dout, dbg_state
    );

    // Arbiter side
    modport slave (
        input  req, rep_cnt, abort,
        output gnt, busy, done, sel1, sel2, sel3, sel4, mux1, mux2, Aout, Dout, dbg_state
    );
endinterface

// File: rtl/dp_seq_arbiter.sv
// Round-robin arbiter that owns the two-stage select/mux datapath controls.
// The winner gets P1-P3 repeated (rep_cnt+1) times, then a flush (P4) and a
// one-cycle done pulse. All outputs decode registered state only.
module dp_seq_arbiter #(
    parameter int NREQ  = 2,
    parameter int REP_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    dp_seq_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [REP_W-1:0] cnt_q, cnt_d;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_valid && bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

    // State, winner, pointer and iteration-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: phase sequencing, grant capture and abort handling.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_P1;
                    win_d   = pick_idx;
                    cnt_d   = bus.rep_cnt;
                    ptr_d   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            S_P1: state_d = S_P2;
            S_P2: state_d = S_P3;
            S_P3: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = S_P1;
                end else begin
                    state_d = S_P4;
                end
            end
            S_P4:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort cancels any active operation; the pointer stays advanced so
        // the aborted requester does not regain top priority.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Output decode of registered state and winner.
    always_comb begin
        bus.gnt       = '0;
        bus.done      = '0;
        bus.busy      = 1'b0;
        bus.sel1      = 1'b0;
        bus.sel2      = 1'b0;
        bus.sel3      = 1'b0;
        bus.sel4      = 1'b0;
        bus.mux1      = 1'b0;
        bus.mux2      = 1'b0;
        bus.Aout      = 1'b0;
        bus.Dout      = 1'b0;
        bus.dbg_state = state_q;
        if (state_q != S_IDLE) begin
            bus.busy       = 1'b1;
            bus.gnt[win_q] = 1'b1;
        end
        case (state_q)
            S_P1: begin
                bus.sel1 = 1'b1;
                bus.sel3 = 1'b1;
                bus.Aout = 1'b1;
                bus.Dout = 1'b1;
            end
            S_P2: begin
                bus.sel2 = 1'b1;
                bus.sel4 = 1'b1;
            end
            S_P3: begin
                bus.sel2 = 1'b1;
                bus.sel4 = 1'b1;
                bus.mux1 = 1'b1;
                bus.mux2 = 1'b1;
                bus.Aout = 1'b1;
                bus.Dout = 1'b1;
            end
            S_DONE:  bus.done[win_q] = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dp_seq_arbiter.sv
// Bench for dp_seq_arbiter: every cycle's expected output vector is queued
// when stimulus is applied and compared on the following falling edge.
module tb_dp_seq_arbiter;
    localparam int NREQ  = 2;
    localparam int REP_W = 4;
    localparam int W     = 2 * NREQ + 9;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dp_seq_arbiter_if #(.NREQ(NREQ), .REP_W(REP_W)) bus ();

    dp_seq_arbiter #(.NREQ(NREQ), .REP_W(REP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] obs;
    assign obs = {bus.gnt, bus.done, bus.busy, bus.sel1, bus.sel2, bus.sel3, bus.sel4,
                  bus.mux1, bus.mux2, bus.Aout, bus.Dout};

    // Single comparison point
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected output vector for a phase (0 idle, 1..4 = P1..P4, 5 done)
    function automatic logic [W-1:0] exp_vec(input int ph, input int w);
        logic [NREQ-1:0] g, d;
        logic b, s1, s2, s3, s4, m1, m2, a, dd;
        g = '0; d = '0; b = 1'b0;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
        m1 = 1'b0; m2 = 1'b0; a = 1'b0; dd = 1'b0;
        if (ph != 0) begin
            g[w] = 1'b1;
            b    = 1'b1;
        end
        case (ph)
            1: begin s1 = 1'b1; s3 = 1'b1; a = 1'b1; dd = 1'b1; end
            2: begin s2 = 1'b1; s4 = 1'b1; end
            3: begin s2 = 1'b1; s4 = 1'b1; m1 = 1'b1; m2 = 1'b1; a = 1'b1; dd = 1'b1; end
            5: d[w] = 1'b1;
            default: ;
        endcase
        return {g, d, b, s1, s2, s3, s4, m1, m2, a, dd};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(0, 0));
    endtask

    task automatic push_phases(input int w, input int passes);
        for (int p = 0; p < passes; p++) begin
            exp_q.push_back(exp_vec(1, w));
            exp_q.push_back(exp_vec(2, w));
            exp_q.push_back(exp_vec(3, w));
        end
    endtask

    task automatic push_op(input int w, input int r);
        push_phases(w, r + 1);
        exp_q.push_back(exp_vec(4, w));
        exp_q.push_back(exp_vec(5, w));
    endtask

    // Advance until only lvl expected entries remain (current cycle included)
    task automatic wait_level(input int lvl);
        int budget;
        budget = 500;
        while (exp_q.size() > lvl && budget > 0) begin
            tick();
            budget--;
        end
        if (exp_q.size() > lvl) check_eq("wait_timeout", 32'(exp_q.size()), 32'(lvl));
    endtask

    // Scoreboard: pop and compare on every falling edge with an expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check_eq($sformatf("outs st=%0d", bus.dbg_state), 32'(obs), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, r;
        rst         = 1'b1;
        bus.req     = '1;
        bus.rep_cnt = '0;
        bus.abort   = 1'b0;

        // Reset held two cycles with all requests up: outputs quiet
        tick();
        push_idle(1);
        tick();
        rst = 1'b0;

        // First grant goes to requester 0, then strict alternation
        push_idle(1);
        for (int k = 0; k < 4; k++) begin
            push_op(k % 2, 0);
            if (k < 3) push_idle(1);
        end
        wait_level(1);

        // Repeat count 2; rep_cnt and req changes mid-operation are ignored
        bus.req     = 2'b01;
        bus.rep_cnt = 4'd2;
        push_idle(1);
        push_op(0, 2);
        wait_level(10);
        bus.rep_cnt = 4'd7;
        bus.req     = '0;
        wait_level(1);

        // Abort during P2 of requester 1; next grant goes to requester 0
        bus.req     = 2'b11;
        bus.rep_cnt = '0;
        push_idle(1);
        push_phases(1, 0);
        exp_q.push_back(exp_vec(1, 1));
        exp_q.push_back(exp_vec(2, 1));
        wait_level(1);
        bus.abort = 1'b1;
        push_idle(1);
        push_op(0, 0);
        tick();
        bus.abort = 1'b0;
        wait_level(1);

        // Reset during P3 with counter 3; pointer returns to requester 0
        bus.rep_cnt = 4'd3;
        push_idle(1);
        push_phases(1, 1);
        wait_level(1);
        rst = 1'b1;
        push_idle(1);
        tick();
        rst         = 1'b0;
        bus.rep_cnt = '0;
        push_op(0, 0);
        wait_level(1);

        // Single-requester operations, including the maximum repeat count
        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(0, NREQ - 1);
            r = (i == 0) ? 15 : $urandom_range(0, 15);
            bus.req     = '0;
            bus.req[w]  = 1'b1;
            bus.rep_cnt = REP_W'(r);
            push_idle(1);
            push_op(w, r);
            wait_level(1);
        end

        bus.req = '0;
        push_idle(3);
        wait_level(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/dp_seq_arbiter.md
Name: dp_seq_arbiter

Overview:
- Round-robin scheduler that shares the two-stage select/mux datapath between NREQ requesters.
- Grants one requester at a time and latches that requester's repeat count.
- Sequences the datapath select lines (sel1..sel4, mux1, mux2, Aout, Dout) through a fixed phase pattern, then returns a one-cycle done pulse to the winner.
- Sits between the requesting engines and the datapath; it is the only driver of the datapath controls.

Parameters:
- NREQ, 2, number of requesters (legal 2..8)
- REP_W, 4, width of the repeat-count input

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level, held until matching done
- rep_cnt  input  REP_W  extra iterations of phases P1-P3, sampled only at grant
- abort  input  1  synchronous abort of the current operation
- gnt  output  NREQ  one-hot grant, held from P1 through DONE
- busy  output  1  high in every state except IDLE
- done  output  NREQ  one-hot, one-cycle completion pulse to the winner
- sel1, sel2, sel3, sel4, mux1, mux2, Aout, Dout  output  1 each  datapath controls

Behaviour:
- Reset: the synchronous reset takes effect on the clk edge where rst=1.
  - State goes to IDLE; all outputs are 0.
  - Iteration counter is 0.
  - Round-robin pointer is set so requester 0 has highest priority.
  - rst has priority over every other input.
- Output decode: every output is a pure decode of registered state, winner and counter. No combinational path from any input to any output. No # delays.
- States: IDLE, P1, P2, P3, P4, DONE.
- IDLE:
  - All controls 0; gnt=0; busy=0.
  - If any req bit is set, the next edge goes to P1. On that edge: the winner is latched, rep_cnt is loaded into the iteration counter, and the pointer is set to winner+1 (mod NREQ).
  - Round-robin search starts at the pointer and scans upward with wrap.
- P1: sel1=1, sel3=1, Aout=1, Dout=1; all other controls 0. Next state P2.
- P2: sel2=1, sel4=1; all other controls 0. Next state P3.
- P3: sel2=1, sel4=1, mux1=1, mux2=1, Aout=1, Dout=1; sel1=0, sel3=0.
  - If counter != 0: decrement the counter and go to P1.
  - Otherwise go to P4.
- P4 (flush): all controls 0. Next state DONE.
- DONE: all controls 0; done[winner]=1 for this one cycle. Next state IDLE, unconditionally.
- Latency:
  - req seen in IDLE gives P1 one cycle later.
  - Total busy cycles = 3*(R+1)+2, where R is the latched repeat count.
  - The minimum gap between consecutive operations is one IDLE cycle.
- Width rules:
  - The counter is REP_W bits and is never negative.
  - rep_cnt = 2^REP_W-1 runs 2^REP_W passes with no wrap.
- abort:
  - In P1-P4 or DONE, the next edge forces IDLE. No done pulse is issued, counter cleared to 0, pointer keeps its already-advanced value.
  - Ignored in IDLE.
- During an operation:
  - req deassertion does not abort; the sequence completes and done still pulses.
  - Changes to rep_cnt and to other req bits are ignored.
- If the winner still holds req in the IDLE cycle after DONE, it competes again under round-robin; with other requesters pending it loses priority.
- Exactly one gnt bit is high, or none. At most one done bit is high.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with req=all-ones → all outputs 0, busy=0. The first grant after release goes to requester 0.
- Single operation: req=01, rep_cnt=0 → the sequence P1,P2,P3,P4,DONE follows one cycle after req.
  - Control patterns must be exact per phase.
  - gnt=01 for 5 cycles; done=01 pulses only in cycle 5; busy is high for 5 cycles.
- Repeat count: rep_cnt=2 → P1-P3 executes 3 times (9 cycles), then P4 and DONE, for 11 busy cycles.
  - Changing rep_cnt to 7 mid-operation has no effect.
- Fairness: req=11 held, rep_cnt=0 → grants alternate 01, 10, 01, 10. Each operation is 5 cycles with 1 IDLE gap between operations.
- Abort: abort=1 for one cycle during P2 of requester 1 → IDLE next cycle, all controls 0, no done pulse. With req=11 the next grant goes to requester 0.
- Reset mid-operation: rst=1 during P3 with counter=3 → IDLE next edge, outputs 0. After release, requester 0 has priority again.
